// File: rtl/exe_mem_req_stage.sv
// Execute stage: effective address, ALE check, store formatting and
// data-SRAM request issue with orphaned-response discard after a flush.
module exe_mem_req_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        ds_to_es_valid,
    output logic        es_allowin,
    input  logic [31:0] ds_pc,
    input  logic [31:0] ds_rj_value,
    input  logic [31:0] ds_rkd_value,
    input  logic [31:0] ds_imm,
    input  logic [2:0]  ds_ld_type,
    input  logic [1:0]  ds_st_type,
    input  logic        ds_ex_in,
    input  logic [14:0] ds_ex_code_in,
    input  logic        ms_allowin,
    output logic        es_to_ms_valid,
    output logic [2:0]  es_ld_type,
    output logic [31:0] es_addr,
    output logic [31:0] es_pc,
    output logic        es_ex,
    output logic [14:0] es_ex_code,
    output logic [31:0] es_badv,
    input  logic        mem_ex,
    input  logic        mem_ertn_flush,
    input  logic        wb_ex,
    input  logic        wb_ertn_flush,
    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [1:0]  data_sram_size,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_REQ,
        S_ACK
    } state_t;

    localparam logic [2:0]  LD_W    = 3'b000;
    localparam logic [2:0]  LD_B    = 3'b001;
    localparam logic [2:0]  LD_H    = 3'b010;
    localparam logic [2:0]  LD_BU   = 3'b011;
    localparam logic [2:0]  LD_HU   = 3'b100;
    localparam logic [2:0]  LD_NONE = 3'b111;
    localparam logic [1:0]  ST_NONE = 2'b00;
    localparam logic [1:0]  ST_B    = 2'b01;
    localparam logic [1:0]  ST_H    = 2'b10;
    localparam logic [1:0]  ST_W    = 2'b11;
    localparam logic [14:0] ALE_CODE = {6'h09, 9'h0};

    function automatic logic ale_chk(
        input logic [2:0] ld,
        input logic [1:0] st,
        input logic [1:0] lo
    );
        logic half;
        logic word;
        half = (ld == LD_H) | (ld == LD_HU) | (st == ST_H);
        word = (ld == LD_W) | (st == ST_W);
        return (half & lo[0]) | (word & (lo != 2'b00));
    endfunction

    function automatic logic is_mem(
        input logic [2:0] ld,
        input logic [1:0] st
    );
        return (ld != LD_NONE) | (st != ST_NONE);
    endfunction

    state_t      state;
    state_t      state_n;
    logic        discard;
    logic        discard_n;

    logic [31:0] pc_r;
    logic [31:0] rj_r;
    logic [31:0] rkd_r;
    logic [31:0] imm_r;
    logic [2:0]  ld_type_r;
    logic [1:0]  st_type_r;
    logic        ex_in_r;
    logic [14:0] ex_code_r;

    logic        flush;
    logic        valid;
    logic        ready_go;
    logic        latch;
    logic        ale;
    logic [31:0] ds_addr;
    logic        ds_go_req;
    state_t      ds_target;

    assign flush   = wb_ex | wb_ertn_flush;
    assign es_addr = rj_r + imm_r;
    assign ale     = ale_chk(ld_type_r, st_type_r, es_addr[1:0]);

    // Incoming instruction is classified up front so latch picks HOLD or REQ.
    assign ds_addr   = ds_rj_value + ds_imm;
    assign ds_go_req = is_mem(ds_ld_type, ds_st_type) & ~ds_ex_in
                     & ~ale_chk(ds_ld_type, ds_st_type, ds_addr[1:0]);
    assign ds_target = ds_go_req ? S_REQ : S_HOLD;

    assign latch = ds_to_es_valid & es_allowin & ~flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            discard <= 1'b0;
        end else begin
            state   <= state_n;
            discard <= discard_n;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_r      <= 32'h0;
            rj_r      <= 32'h0;
            rkd_r     <= 32'h0;
            imm_r     <= 32'h0;
            ld_type_r <= LD_NONE;
            st_type_r <= ST_NONE;
            ex_in_r   <= 1'b0;
            ex_code_r <= 15'h0;
        end else if (latch) begin
            pc_r      <= ds_pc;
            rj_r      <= ds_rj_value;
            rkd_r     <= ds_rkd_value;
            imm_r     <= ds_imm;
            ld_type_r <= ds_ld_type;
            st_type_r <= ds_st_type;
            ex_in_r   <= ds_ex_in;
            ex_code_r <= ds_ex_code_in;
        end
    end

    always_comb begin
        state_n   = state;
        discard_n = discard;
        if (flush) begin
            state_n = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (ds_to_es_valid) state_n = ds_target;
                end
                S_REQ: begin
                    if (data_sram_req & data_sram_addr_ok) state_n = S_ACK;
                end
                S_HOLD, S_ACK: begin
                    if (ms_allowin)
                        state_n = ds_to_es_valid ? ds_target : S_IDLE;
                end
                default: state_n = S_IDLE;
            endcase
        end
        // A flush after acceptance orphans one response; swallow it here.
        if (flush & (state == S_ACK))
            discard_n = 1'b1;
        else if (data_sram_data_ok)
            discard_n = 1'b0;
    end

    always_comb begin
        valid          = state != S_IDLE;
        ready_go       = (state == S_HOLD) | (state == S_ACK);
        es_allowin     = (state == S_IDLE) | (ready_go & ms_allowin);
        es_to_ms_valid = ready_go & valid & ~flush;
        data_sram_req  = (state == S_REQ) & ~discard & ~mem_ex
                       & ~mem_ertn_flush & ~flush;
    end

    always_comb begin
        es_pc      = pc_r;
        es_ld_type = ld_type_r;
        es_ex      = valid & (ex_in_r | ale);
        es_ex_code = 15'h0;
        es_badv    = 32'h0;
        if (valid & ex_in_r) begin
            es_ex_code = ex_code_r;
        end else if (valid & ale) begin
            es_ex_code = ALE_CODE;
            es_badv    = es_addr;
        end
    end

    always_comb begin
        data_sram_addr  = es_addr;
        data_sram_wr    = st_type_r != ST_NONE;
        data_sram_wstrb = 4'h0;
        data_sram_wdata = 32'h0;
        data_sram_size  = 2'd2;
        unique case (st_type_r)
            ST_B: begin
                data_sram_wstrb = 4'b0001 << es_addr[1:0];
                data_sram_wdata = {4{rkd_r[7:0]}};
                data_sram_size  = 2'd0;
            end
            ST_H: begin
                data_sram_wstrb = 4'b0011 << es_addr[1:0];
                data_sram_wdata = {2{rkd_r[15:0]}};
                data_sram_size  = 2'd1;
            end
            ST_W: begin
                data_sram_wstrb = 4'hF;
                data_sram_wdata = rkd_r;
                data_sram_size  = 2'd2;
            end
            default: begin
                unique case (ld_type_r)
                    LD_B, LD_BU: data_sram_size = 2'd0;
                    LD_H, LD_HU: data_sram_size = 2'd1;
                    default:     data_sram_size = 2'd2;
                endcase
            end
        endcase
    end

endmodule
